// File: rtl/weight_bram_sequencer.sv
// Sequencer for one single-port weight BRAM: loads DEPTH host words, then streams
// them back in address order to the MAC through a 2-entry valid/ready output FIFO.
module weight_bram_sequencer #(
    parameter int DEPTH = 28,
    parameter int AW    = 5,
    parameter int DW    = 16
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          LOAD_START,
    input  logic          LD_VALID,
    input  logic [DW-1:0] LD_DATA,
    output logic          LD_READY,
    input  logic          START,
    output logic          BUSY,
    output logic          DONE,
    output logic          W_VALID,
    output logic [DW-1:0] W_DATA,
    output logic          W_LAST,
    input  logic          W_READY,
    output logic [AW-1:0] BRAM_ADDR,
    output logic [DW-1:0] BRAM_DI,
    output logic          BRAM_EN,
    output logic          BRAM_WE,
    input  logic [DW-1:0] BRAM_DO
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_FETCH = 2'd2;
    localparam logic [1:0] S_FLUSH = 2'd3;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] wr_cnt_q, wr_cnt_d;
    logic [AW-1:0] rd_cnt_q, rd_cnt_d;
    logic          done_q, done_d;
    logic          bram_en_q, bram_en_d;
    logic          bram_we_q, bram_we_d;
    logic [AW-1:0] bram_addr_q, bram_addr_d;
    logic [DW-1:0] bram_di_q, bram_di_d;
    logic          rd_last_q, rd_last_d;
    logic [DW-1:0] fifo_data_q [2];
    logic [DW-1:0] fifo_data_d [2];
    logic [1:0]    fifo_last_q, fifo_last_d;
    logic          wr_ptr_q, wr_ptr_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic [1:0]    count_q, count_d;

    logic          push;
    logic          pop;
    logic          issue;
    logic [1:0]    committed;

    // A read issued last edge lands in the FIFO on the next edge, so it already
    // owns a slot; counting it keeps the FIFO from ever overflowing.
    assign push      = bram_en_q & ~bram_we_q;
    assign pop       = W_VALID & W_READY;
    assign committed = count_q - {1'b0, pop} + {1'b0, push};

    assign W_VALID   = (count_q != 2'd0);
    assign W_DATA    = fifo_data_q[rd_ptr_q];
    assign W_LAST    = W_VALID & fifo_last_q[rd_ptr_q];
    assign LD_READY  = (state_q == S_LOAD);
    assign BUSY      = (state_q != S_IDLE);
    assign DONE      = done_q;
    assign BRAM_EN   = bram_en_q;
    assign BRAM_WE   = bram_we_q;
    assign BRAM_ADDR = bram_addr_q;
    assign BRAM_DI   = bram_di_q;

    always_comb begin
        state_d     = state_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        done_d      = 1'b0;
        bram_en_d   = 1'b0;
        bram_we_d   = 1'b0;
        bram_addr_d = bram_addr_q;
        bram_di_d   = bram_di_q;
        rd_last_d   = 1'b0;
        issue       = 1'b0;
        case (state_q)
            S_IDLE: begin
                // The first read goes out on the START edge itself to save a cycle.
                if (LOAD_START) state_d = S_LOAD;
                else if (START) issue = 1'b1;
            end
            S_LOAD: begin
                if (LD_VALID) begin
                    bram_en_d   = 1'b1;
                    bram_we_d   = 1'b1;
                    bram_addr_d = wr_cnt_q;
                    bram_di_d   = LD_DATA;
                    if (wr_cnt_q == LAST_ADDR) begin
                        wr_cnt_d = '0;
                        state_d  = S_IDLE;
                        done_d   = 1'b1;
                    end else begin
                        wr_cnt_d = wr_cnt_q + 1'b1;
                    end
                end
            end
            S_FETCH: issue = (committed < 2'd2);
            S_FLUSH: begin
                if (pop && W_LAST) begin
                    state_d  = S_IDLE;
                    done_d   = 1'b1;
                    rd_cnt_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (issue) begin
            bram_en_d   = 1'b1;
            bram_addr_d = rd_cnt_q;
            rd_last_d   = (rd_cnt_q == LAST_ADDR);
            if (rd_cnt_q == LAST_ADDR) begin
                state_d = S_FLUSH;
            end else begin
                rd_cnt_d = rd_cnt_q + 1'b1;
                state_d  = S_FETCH;
            end
        end
    end

    always_comb begin
        fifo_data_d = fifo_data_q;
        fifo_last_d = fifo_last_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = committed;
        if (push) begin
            fifo_data_d[wr_ptr_q] = BRAM_DO;
            fifo_last_d[wr_ptr_q] = rd_last_q;
            wr_ptr_d              = ~wr_ptr_q;
        end
        if (pop) rd_ptr_d = ~rd_ptr_q;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q        <= S_IDLE;
            wr_cnt_q       <= '0;
            rd_cnt_q       <= '0;
            done_q         <= 1'b0;
            bram_en_q      <= 1'b0;
            bram_we_q      <= 1'b0;
            bram_addr_q    <= '0;
            bram_di_q      <= '0;
            rd_last_q      <= 1'b0;
            fifo_data_q[0] <= '0;
            fifo_data_q[1] <= '0;
            fifo_last_q    <= '0;
            wr_ptr_q       <= 1'b0;
            rd_ptr_q       <= 1'b0;
            count_q        <= '0;
        end else begin
            state_q     <= state_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            done_q      <= done_d;
            bram_en_q   <= bram_en_d;
            bram_we_q   <= bram_we_d;
            bram_addr_q <= bram_addr_d;
            bram_di_q   <= bram_di_d;
            rd_last_q   <= rd_last_d;
            fifo_data_q <= fifo_data_d;
            fifo_last_q <= fifo_last_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end
endmodule

// File: tb/tb_weight_bram_sequencer.sv
// Bench for weight_bram_sequencer: falling-edge BRAM model, directed load/stream
// scenarios and a per-cycle scoreboard of write order, read order and handshakes.
module tb_weight_bram_sequencer;
    localparam int DEPTH = 28;
    localparam int AW    = 5;
    localparam int DW    = 16;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          LOAD_START, LD_VALID, LD_READY, START, BUSY, DONE;
    logic          W_VALID, W_LAST, W_READY, BRAM_EN, BRAM_WE;
    logic [DW-1:0] LD_DATA, W_DATA, BRAM_DI, BRAM_DO;
    logic [AW-1:0] BRAM_ADDR;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] weights [DEPTH];
    logic [3:0]    rdy_pat = 4'b1001;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int mode     = 0;
    int n_wr     = 0;
    int n_issue  = 0;
    int n_hs     = 0;
    bit done_flag = 1'b0;
    int done_cyc = 0;
    int first_v_cyc = -1;
    int last_hs_cyc = -1;
    logic [DW-1:0] first_data = '0;
    logic [DW-1:0] last_data  = '0;
    bit prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    int d, t0;

    weight_bram_sequencer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .CLK(CLK), .RST_N(RST_N), .LOAD_START(LOAD_START), .LD_VALID(LD_VALID),
        .LD_DATA(LD_DATA), .LD_READY(LD_READY), .START(START), .BUSY(BUSY), .DONE(DONE),
        .W_VALID(W_VALID), .W_DATA(W_DATA), .W_LAST(W_LAST), .W_READY(W_READY),
        .BRAM_ADDR(BRAM_ADDR), .BRAM_DI(BRAM_DI), .BRAM_EN(BRAM_EN), .BRAM_WE(BRAM_WE),
        .BRAM_DO(BRAM_DO)
    );

    always #5 CLK = ~CLK;

    // Single-port BRAM: controls sampled on the falling edge, read data registered.
    always @(negedge CLK) begin
        if (BRAM_EN) begin
            if (BRAM_WE) mem[BRAM_ADDR] <= BRAM_DI;
            else         BRAM_DO <= mem[BRAM_ADDR];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: writes land at 0..DEPTH-1 with the loaded words, reads are issued
    // in address order with at most two outstanding, and the MAC sees each weight once.
    task automatic compare_cycle();
        if (!RST_N) begin
            prev_stall = 1'b0;
            mode = 0;
            return;
        end
        if (BRAM_EN && BRAM_WE) begin
            chk("wr_in_load", mode, 1);
            chk("wr_in_range", 32'(n_wr < DEPTH), 1);
            if (n_wr < DEPTH) begin
                chk("wr_addr", 32'(BRAM_ADDR), n_wr);
                chk("wr_data", 32'(BRAM_DI), 32'(weights[n_wr]));
            end
            n_wr++;
        end
        if (BRAM_EN && !BRAM_WE) begin
            chk("rd_in_fetch", mode, 2);
            chk("rd_addr", 32'(BRAM_ADDR), n_issue);
            n_issue++;
            chk("outstanding_le2", 32'((n_issue - n_hs) <= 2), 1);
        end
        if (W_VALID) begin
            chk("w_in_range", 32'(n_hs < DEPTH), 1);
            if (n_hs < DEPTH) begin
                chk("w_data", 32'(W_DATA), 32'(weights[n_hs]));
                chk("w_last", 32'(W_LAST), 32'(n_hs == DEPTH - 1));
            end
            if (prev_stall) chk("stall_hold", 32'(W_DATA), 32'(prev_data));
            if (first_v_cyc < 0) first_v_cyc = cyc;
            if (W_READY) begin
                if (n_hs == 0) first_data = W_DATA;
                if (W_LAST) begin
                    last_data   = W_DATA;
                    last_hs_cyc = cyc;
                end
                n_hs++;
            end
        end else if (prev_stall) begin
            chk("stall_valid_kept", 32'(W_VALID), 1);
        end
        prev_stall = W_VALID && !W_READY;
        prev_data  = W_DATA;
        if (DONE) begin
            chk("done_busy_low", 32'(BUSY), 0);
            if (mode == 1) chk("load_word_count", n_wr, DEPTH);
            else           chk("fetch_word_count", n_hs, DEPTH);
            done_flag = 1'b1;
            done_cyc  = cyc;
        end
        if (!BUSY && LOAD_START) begin
            mode = 1;
            n_wr = 0;
            done_flag = 1'b0;
        end else if (!BUSY && START) begin
            mode = 2;
            n_issue = 0;
            n_hs = 0;
            done_flag = 1'b0;
            first_v_cyc = -1;
            last_hs_cyc = -1;
        end
    endtask

    task automatic tick();
        @(negedge CLK);
        #1;
        compare_cycle();
        @(posedge CLK);
        cyc++;
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_ld_ready"}, 32'(LD_READY), 0);
        chk({tag, "_busy"}, 32'(BUSY), 0);
        chk({tag, "_done"}, 32'(DONE), 0);
        chk({tag, "_w_valid"}, 32'(W_VALID), 0);
        chk({tag, "_w_last"}, 32'(W_LAST), 0);
        chk({tag, "_bram_en"}, 32'(BRAM_EN), 0);
        chk({tag, "_bram_we"}, 32'(BRAM_WE), 0);
        chk({tag, "_w_data"}, 32'(W_DATA), 0);
        chk({tag, "_bram_addr"}, 32'(BRAM_ADDR), 0);
        chk({tag, "_bram_di"}, 32'(BRAM_DI), 0);
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (!done_flag && k < budget) begin
            tick();
            k++;
        end
        chk("done_seen", 32'(done_flag), 1);
    endtask

    task automatic do_load(input bit also_start, input bit gapped, output int dcyc);
        int idx, c, start_cyc;
        bit acc;
        idx = 0;
        c = 0;
        done_flag = 1'b0;
        start_cyc = cyc;
        LOAD_START = 1'b1;
        START = also_start;
        tick();
        LOAD_START = 1'b0;
        START = 1'b0;
        chk("ld_ready_in_load", 32'(LD_READY), 1);
        while (idx < DEPTH && c < 400) begin
            LD_VALID = !gapped || (c % 3 == 2);
            LD_DATA  = weights[idx];
            acc = LD_VALID && LD_READY;
            tick();
            if (acc) idx++;
            c++;
        end
        LD_VALID = 1'b0;
        wait_done(10);
        dcyc = done_cyc - start_cyc;
    endtask

    task automatic do_stream(input bit toggled, input int rst_at, output int start_cyc);
        int k;
        done_flag = 1'b0;
        start_cyc = cyc;
        START = 1'b1;
        tick();
        START = 1'b0;
        k = 0;
        while (!done_flag && k < 400) begin
            if (rst_at >= 0 && n_hs == rst_at) break;
            W_READY = toggled ? rdy_pat[k % 4] : 1'b1;
            START = toggled && (k == 6);
            tick();
            k++;
        end
        START = 1'b0;
        W_READY = 1'b1;
        if (rst_at < 0) chk("stream_done", 32'(done_flag), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        RST_N = 1'b0;
        LOAD_START = 1'b0;
        LD_VALID = 1'b0;
        LD_DATA = '0;
        START = 1'b0;
        W_READY = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check_idle_outputs("por");
        RST_N = 1'b1;
        tick();
        tick();

        // Continuous load of 0x0001..0x001C.
        for (int i = 0; i < DEPTH; i++) weights[i] = 16'(i + 1);
        do_load(1'b0, 1'b0, d);
        chk("load_done_offset", d, 29);
        chk("ld_ready_after_load", 32'(LD_READY), 0);
        chk("mem_addr0", 32'(mem[0]), 32'h0001);
        chk("mem_addr27", 32'(mem[27]), 32'h001C);
        tick();

        // Full-rate stream.
        do_stream(1'b0, -1, t0);
        chk("first_valid_offset", first_v_cyc - t0, 2);
        chk("last_offset", last_hs_cyc - t0, 29);
        chk("fetch_done_offset", done_cyc - t0, 30);
        chk("first_word", 32'(first_data), 32'h0001);
        chk("last_word", 32'(last_data), 32'h001C);
        tick();

        // Backpressured stream with a START pulse injected mid-fetch.
        do_stream(1'b1, -1, t0);
        chk("bp_last_word", 32'(last_data), 32'h001C);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("quiet_busy", 32'(BUSY), 0);
            chk("quiet_w_valid", 32'(W_VALID), 0);
        end

        // LOAD_START and START together, gapped host stream of a second weight set.
        for (int i = 0; i < DEPTH; i++) weights[i] = 16'hA000 + 16'(i * 257);
        do_load(1'b1, 1'b1, d);
        chk("gap_load_done_offset", d, 85);
        chk("mem2_addr0", 32'(mem[0]), 32'hA000);
        chk("mem2_addr27", 32'(mem[27]), 32'hBB1B);
        tick();

        // Asynchronous reset in the middle of a fetch.
        do_stream(1'b0, 10, t0);
        chk("reached_word10", n_hs, 10);
        chk("busy_mid_fetch", 32'(BUSY), 1);
        #2 RST_N = 1'b0;
        #1 check_idle_outputs("async_rst");
        tick();
        tick();
        RST_N = 1'b1;
        tick();

        // Fresh stream after reset restarts from address 0.
        do_stream(1'b0, -1, t0);
        chk("rst_first_valid_offset", first_v_cyc - t0, 2);
        chk("rst_fetch_done_offset", done_cyc - t0, 30);
        chk("rst_first_word", 32'(first_data), 32'hA000);
        chk("rst_last_word", 32'(last_data), 32'hBB1B);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/weight_bram_sequencer.md
# weight_bram_sequencer

Sequencer for one single-port weight BRAM of the ANN layer: a 16-bit word memory of DEPTH entries that captures address/control on the falling clock edge and registers read data. The block loads DEPTH weights from a host stream into the BRAM, then on command streams them back in address order (0..DEPTH-1) to the neuron MAC over a valid/ready interface with backpressure. It is the only master of the BRAM port; one instance sits beside each weight BRAM.

## Interface
- DEPTH, 28, number of weight words per neuron (addresses 0..DEPTH-1)
- AW, 5, BRAM address width; requires DEPTH <= 2^AW
- DW, 16, weight word width
- CLK  in  1  system clock; all block logic on rising edge
- RST_N  in  1  asynchronous, active-low reset
- LOAD_START  in  1  pulse in IDLE: begin loading DEPTH words
- LD_VALID  in  1  host word valid
- LD_DATA  in  DW  host weight word
- LD_READY  out  1  block accepts LD_DATA this cycle
- START  in  1  pulse in IDLE: begin streaming DEPTH words to MAC
- BUSY  out  1  high in any state other than IDLE
- DONE  out  1  one-cycle pulse when a load or fetch completes
- W_VALID  out  DW-less flag, 1  weight word available
- W_DATA  out  DW  weight word
- W_LAST  out  1  marks word at address DEPTH-1
- W_READY  in  1  MAC accepts W_DATA
- BRAM_ADDR  out  AW  BRAM address
- BRAM_DI  out  DW  BRAM write data
- BRAM_EN  out  1  BRAM enable
- BRAM_WE  out  1  BRAM write enable
- BRAM_DO  in  DW  BRAM registered read data

## Operation
- States: IDLE, LOAD, FETCH, FLUSH. Reset: IDLE; LD_READY, BUSY, DONE, W_VALID, W_LAST, BRAM_EN, BRAM_WE = 0; W_DATA, BRAM_ADDR, BRAM_DI = 0; counters 0; output FIFO empty.
- IDLE: LOAD_START -> LOAD; else START -> FETCH. Both high same cycle: LOAD wins, START dropped. Both ignored outside IDLE.
- LOAD: LD_READY = 1. Each cycle with LD_VALID: register BRAM_EN=1, BRAM_WE=1, BRAM_ADDR=wr_cnt, BRAM_DI=LD_DATA; wr_cnt++. Accepting word DEPTH-1 -> IDLE, DONE pulse, wr_cnt cleared. Cycles without LD_VALID drive BRAM_EN=0, BRAM_WE=0.
- FETCH: read issue with BRAM_EN=1, BRAM_WE=0, BRAM_ADDR=rd_cnt when (FIFO occupancy + reads in flight) < 2; rd_cnt++. After issuing address DEPTH-1 -> FLUSH.
- Output path: 2-entry FIFO; BRAM_DO captured into FIFO on the rising edge one cycle after issue. W_VALID = FIFO not empty; W_DATA/W_LAST = head entry. Pop on W_VALID & W_READY. Simultaneous push and pop allowed, occupancy unchanged.
- W_LAST travels with the entry for address DEPTH-1.
- FLUSH: no issue; when last entry (W_LAST) handed off -> IDLE with DONE pulse in the cycle after the handshake; rd_cnt cleared.
- Counters are AW bits, compare to DEPTH-1, never wrap past DEPTH-1.
- RST_N low at any time: immediate return to reset values; partial load leaves BRAM contents undefined for unwritten addresses; in-flight read discarded.

## Timing
- BRAM controls registered on CLK rise, sampled by BRAM on following fall; BRAM_DO valid by next rise. Read latency: issue at rise t -> FIFO push at rise t+1 -> W_VALID high in cycle t+1.
- START at cycle 0 -> first read issued cycle 1 -> W_VALID cycle 2. With W_READY held 1: one word per cycle, W_LAST in cycle DEPTH+1, DONE in cycle DEPTH+2.
- W_READY low: issue stalls within 2 words; no word lost or duplicated; W_DATA held stable while W_VALID & !W_READY.
- LOAD with LD_VALID held 1: DEPTH words in DEPTH cycles; DONE the cycle after last acceptance.
- BUSY rises the cycle after START/LOAD_START, falls together with DONE.

## Test plan
- Load 0x0001..0x001C (LD_VALID always 1) -> 28 writes to addresses 0..27, DONE after 28 cycles, LD_READY low afterwards.
- START, W_READY=1 -> W_DATA 0x0001..0x001C in consecutive cycles from cycle 2, W_LAST only with 0x001C, DONE one cycle later.
- START, W_READY toggling 1,0,0,1 pattern -> exact in-order sequence, no duplicates, W_DATA stable while stalled, never more than 2 reads outstanding.
- LOAD_START and START same cycle in IDLE -> LOAD entered, START ignored; START during FETCH -> no effect.
- LD_VALID gapped (every 3rd cycle) -> BRAM_EN low in gap cycles, addresses still contiguous 0..27.
- RST_N low mid-FETCH at word 10 -> all outputs to reset values asynchronously; new START streams from address 0.
